// File: rtl/jump_physics_if.sv
`default_nettype none
// ============================================================================
//  Module   : jump_physics_if
//  Brief    : Launch request / jump result bundle between game FSM and physics.
//  Revision : 1.0 - initial release
// ============================================================================
interface jump_physics_if;
  logic        i_jump_en;
  logic [10:0] i_jump_v_init;
  logic        o_jump_done;
  logic [10:0] o_jump_dist;
  logic [8:0]  o_jump_height;
  logic        o_busy;

  modport master (
    output i_jump_en,
    output i_jump_v_init,
    input  o_jump_done,
    input  o_jump_dist,
    input  o_jump_height,
    input  o_busy
  );

  modport slave (
    input  i_jump_en,
    input  i_jump_v_init,
    output o_jump_done,
    output o_jump_dist,
    output o_jump_height,
    output o_busy
  );
endinterface
`default_nettype wire

// File: rtl/jump_physics.sv
`default_nettype none
// ============================================================================
//  Module   : jump_physics
//  Brief    : Ballistic jump integrator: launch on en rising edge, step every
//             TICK_DIV clocks, land when height returns to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module jump_physics #(
  parameter int unsigned TICK_DIV = 65536
) (
  input  wire logic     clk_jump,
  input  wire logic     rst_jump,
  jump_physics_if.slave jp
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] c_TICK_MAX = TW'(TICK_DIV - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_FLY  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          en_q;
  logic          armed_q;
  logic [6:0]    v_q, v_d;
  logic [7:0]    vy_q, vy_d;
  logic [13:0]   h_q, h_d;
  logic [15:0]   x_q, x_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic [10:0]   dist_q, dist_d;
  logic [8:0]    height_q, height_d;

  logic          w_launch;
  logic          w_step;
  logic          w_land;
  logic          w_abort;
  logic [14:0]   w_h_sum;
  logic          w_unused;

  assign w_unused = &{1'b0, jp.i_jump_v_init[10:7]};

  // armed_q blocks a launch when en is already high coming out of reset
  assign w_launch = jp.i_jump_en && !en_q && armed_q;
  assign w_step   = (tick_q == c_TICK_MAX);
  assign w_h_sum  = {1'b0, h_q} + {{7{vy_q[7]}}, vy_q};
  assign w_land   = vy_q[7] && (w_h_sum[14] || (w_h_sum == 15'd0));

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    vy_d    = vy_q;
    h_d     = h_q;
    x_d     = x_q;
    tick_d  = tick_q;
    w_abort = 1'b0;

    case (state_q)
      c_IDLE: begin
        if (w_launch) begin
          v_d     = jp.i_jump_v_init[6:0];
          vy_d    = {1'b0, jp.i_jump_v_init[6:0]};
          h_d     = 14'd0;
          x_d     = 16'd0;
          tick_d  = '0;
          state_d = (jp.i_jump_v_init[6:0] == 7'd0) ? c_DONE : c_FLY;
        end
      end
      c_FLY: begin
        if (w_step && w_land) begin
          // landing wins over a simultaneous en drop so the done pulse is seen
          x_d     = x_q + {9'd0, v_q};
          vy_d    = vy_q - 8'd1;
          h_d     = 14'd0;
          tick_d  = '0;
          state_d = c_DONE;
        end else if (!jp.i_jump_en) begin
          w_abort = 1'b1;
          x_d     = 16'd0;
          vy_d    = 8'd0;
          h_d     = 14'd0;
          tick_d  = '0;
          state_d = c_IDLE;
        end else if (w_step) begin
          x_d    = x_q + {9'd0, v_q};
          vy_d   = vy_q - 8'd1;
          h_d    = w_h_sum[13:0];
          tick_d = '0;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      c_DONE: begin
        if (!jp.i_jump_en) begin
          state_d = c_IDLE;
        end
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  always_comb begin
    done_d   = (state_d == c_DONE);
    busy_d   = (state_d == c_FLY);
    height_d = (state_d == c_FLY) ? h_d[13:5] : 9'd0;
    if (state_d == c_IDLE) begin
      dist_d = w_abort ? 11'd0 : dist_q;
    end else begin
      dist_d = {2'b00, x_d[15:7]};
    end
  end

  always_ff @(posedge clk_jump) begin
    if (rst_jump) begin
      state_q  <= c_IDLE;
      en_q     <= 1'b0;
      armed_q  <= 1'b0;
      v_q      <= 7'd0;
      vy_q     <= 8'd0;
      h_q      <= 14'd0;
      x_q      <= 16'd0;
      tick_q   <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      dist_q   <= 11'd0;
      height_q <= 9'd0;
    end else begin
      state_q  <= state_d;
      en_q     <= jp.i_jump_en;
      armed_q  <= armed_q || !jp.i_jump_en;
      v_q      <= v_d;
      vy_q     <= vy_d;
      h_q      <= h_d;
      x_q      <= x_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      dist_q   <= dist_d;
      height_q <= height_d;
    end
  end

  assign jp.o_jump_done   = done_q;
  assign jp.o_busy        = busy_q;
  assign jp.o_jump_dist   = dist_q;
  assign jp.o_jump_height = height_q;

endmodule
`default_nettype wire

// File: tb/tb_jump_physics.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jump_physics
//  Brief    : Directed bench for jump_physics with TICK_DIV=1 and TICK_DIV=4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jump_physics;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jump_physics_if if1 ();
  jump_physics_if if4 ();

  jump_physics #(.TICK_DIV(1)) u_dut1 (.clk_jump(clk), .rst_jump(rst), .jp(if1.slave));
  jump_physics #(.TICK_DIV(4)) u_dut4 (.clk_jump(clk), .rst_jump(rst), .jp(if4.slave));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // returns at the first negedge after the launch edge
  task automatic launch1(input logic [10:0] v);
    @(negedge clk) if1.i_jump_en = 1'b0;
    @(negedge clk) begin
      if1.i_jump_v_init = v;
      if1.i_jump_en     = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic wait_done1(output int n);
    n = 0;
    while (!if1.o_jump_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    int busy_cnt;
    int max_h;

    if1.i_jump_en = 1'b0; if1.i_jump_v_init = 11'd0;
    if4.i_jump_en = 1'b0; if4.i_jump_v_init = 11'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_done",   if1.o_jump_done,   0);
    check("rst_dist",   if1.o_jump_dist,   0);
    check("rst_height", if1.o_jump_height, 0);
    check("rst_busy",   if1.o_busy,        0);
    rst = 1'b0;

    // v=127, TICK_DIV=1, en held through DONE
    launch1(11'd127);
    check("busy_at_launch", if1.o_busy, 1);
    n = 0;
    while (!if1.o_jump_done && n < 1000) begin
      @(negedge clk);
      n++;
      case (n)
        50:  if1.i_jump_v_init = 11'd5;
        126: check("h_step126", if1.o_jump_height, 253);
        127: check("h_step127", if1.o_jump_height, 254);
        128: begin
          check("h_step128", if1.o_jump_height, 254);
          check("d_step128", if1.o_jump_dist, 127);
        end
        129: check("h_step129", if1.o_jump_height, 253);
        default: ;
      endcase
    end
    check("v127_latency", n, 255);
    check("v127_dist",    if1.o_jump_dist,   253);
    check("v127_height",  if1.o_jump_height, 0);
    check("v127_busy",    if1.o_busy,        0);
    repeat (10) begin
      @(negedge clk);
      check("hold_done", if1.o_jump_done, 1);
      check("hold_busy", if1.o_busy,      0);
    end
    if1.i_jump_en = 1'b0;
    @(negedge clk);
    check("idle_done", if1.o_jump_done, 0);
    check("idle_dist", if1.o_jump_dist, 253);

    // upper v_init bits are ignored
    launch1(11'h7FF);
    wait_done1(n);
    check("v7ff_latency", n, 255);
    check("v7ff_dist", if1.o_jump_dist, 253);

    // v=0 lands immediately
    launch1(11'd0);
    check("v0_done", if1.o_jump_done, 1);
    check("v0_dist", if1.o_jump_dist, 0);
    check("v0_busy", if1.o_busy,      0);

    // abort after step 50
    launch1(11'd127);
    repeat (50) @(negedge clk);
    check("abort_pre_dist",   if1.o_jump_dist,   49);
    check("abort_pre_height", if1.o_jump_height, 160);
    if1.i_jump_en = 1'b0;
    @(negedge clk);
    check("abort_done",   if1.o_jump_done,   0);
    check("abort_dist",   if1.o_jump_dist,   0);
    check("abort_height", if1.o_jump_height, 0);
    check("abort_busy",   if1.o_busy,        0);
    repeat (5) @(negedge clk);
    check("abort_no_done", if1.o_jump_done, 0);

    // reset mid-flight with en held high
    launch1(11'd127);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstfly_busy", if1.o_busy,        0);
    check("rstfly_dist", if1.o_jump_dist,   0);
    check("rstfly_h",    if1.o_jump_height, 0);
    check("rstfly_done", if1.o_jump_done,   0);
    repeat (5) @(negedge clk);
    check("rstfly_nolaunch", if1.o_busy, 0);
    launch1(11'd1);
    wait_done1(n);
    check("v1_latency", n, 3);
    check("v1_dist", if1.o_jump_dist, 0);

    // en low sampled on the landing edge: one-cycle done pulse
    launch1(11'd1);
    @(negedge clk);
    @(negedge clk) if1.i_jump_en = 1'b0;
    @(negedge clk);
    check("pulse_done_hi", if1.o_jump_done, 1);
    @(negedge clk);
    check("pulse_done_lo", if1.o_jump_done, 0);
    check("pulse_busy",    if1.o_busy,      0);

    // TICK_DIV=4, v=16
    @(negedge clk) if4.i_jump_en = 1'b0;
    @(negedge clk) begin
      if4.i_jump_v_init = 11'd16;
      if4.i_jump_en     = 1'b1;
    end
    @(negedge clk);
    n = 0; busy_cnt = 0; max_h = 0;
    while (!if4.o_jump_done && n < 2000) begin
      if (if4.o_busy) busy_cnt++;
      if (int'(if4.o_jump_height) > max_h) max_h = int'(if4.o_jump_height);
      @(negedge clk);
      n++;
    end
    check("td4_latency", n,        132);
    check("td4_busy",    busy_cnt, 132);
    check("td4_peak",    max_h,    4);
    check("td4_dist",    if4.o_jump_dist, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
